// File: rtl/rca_share_arbiter.sv
// rca_share_arbiter
// Shares one pipelined ripple-carry adder among NREQ requesters. A round-robin
// grant picks at most one operation per cycle. That operation's operands are
// registered onto the adder ports. A tag pipeline of matching depth carries the
// requester index, so each sum is steered back to its originating requester.
// Each requester may have only one operation in flight, which is tracked by a
// per-requester busy bit.
module rca_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 4,
   parameter int LATENCY = 3,
   parameter int IDW     = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    hold,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*WIDTH-1:0]   req_a,
   input  logic [NREQ*WIDTH-1:0]   req_b,
   input  logic [NREQ-1:0]         req_cin,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        add_a,
   output logic [WIDTH-1:0]        add_b,
   output logic                    add_cin,
   input  logic [WIDTH-1:0]        add_sum,
   input  logic                    add_cout,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_sum,
   output logic                    rsp_cout,
   output logic                    idle
);

   // Width of a requester index; the pointer and the grant select use exactly this width.
   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0]             busy_reg, busy_next;
   logic [PW-1:0]               ptr_reg, ptr_next;
   logic [LATENCY:0]            tag_valid_reg;
   logic [LATENCY:0][IDW-1:0]   tag_id_reg;
   logic [WIDTH-1:0]            add_a_reg, add_b_reg;
   logic                        add_cin_reg;

   logic [NREQ-1:0]             eligible;
   logic                        grant_any;
   logic [PW-1:0]               grant_sel;
   logic [PW-1:0]               scan_sel;
   logic                        rsp_fire;
   logic [WIDTH-1:0]            opa [NREQ];
   logic [WIDTH-1:0]            opb [NREQ];

   // Per-requester slices of the packed operand buses, plus grant and response decodes.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign opa[gi]       = req_a[gi*WIDTH +: WIDTH];
         assign opb[gi]       = req_b[gi*WIDTH +: WIDTH];
         assign req_ready[gi] = grant_any && (grant_sel == PW'(gi));
         assign rsp_valid[gi] = rsp_fire && (tag_id_reg[LATENCY] == IDW'(gi));
      end
   endgenerate

   // Requests that may be granted this cycle; nothing is granted while reset or hold is asserted.
   always_comb begin
      eligible = '0;
      if (rst_n && !hold) begin
         eligible = req_valid & ~busy_reg;
      end
   end

   // Round-robin scan starting at the pointer; the first eligible requester wins.
   always_comb begin
      grant_any = 1'b0;
      grant_sel = '0;
      scan_sel  = '0;
      for (int off = 0; off < NREQ; off++) begin
         scan_sel = PW'((int'(ptr_reg) + off) % NREQ);
         if (!grant_any && eligible[scan_sel]) begin
            grant_any = 1'b1;
            grant_sel = scan_sel;
         end
      end
   end

   // Next pointer and busy bits. A response clears its busy bit at the same edge
   // that may set another one. The clear and the set can never target the same
   // requester, because a busy requester is not eligible.
   always_comb begin
      ptr_next  = ptr_reg;
      busy_next = (busy_reg & ~rsp_valid) | req_ready;
      if (grant_any) begin
         ptr_next = PW'((int'(grant_sel) + 1) % NREQ);
      end
   end

   // Arbitration state and adder operand registers; the operands hold their value when nothing issues.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_reg    <= '0;
         ptr_reg     <= '0;
         add_a_reg   <= '0;
         add_b_reg   <= '0;
         add_cin_reg <= 1'b0;
      end else begin
         busy_reg <= busy_next;
         ptr_reg  <= ptr_next;
         if (grant_any) begin
            add_a_reg   <= opa[grant_sel];
            add_b_reg   <= opb[grant_sel];
            add_cin_reg <= req_cin[grant_sel];
         end
      end
   end

   // The tag pipeline shifts every cycle. Stage 0 captures the grant, and stage LATENCY lines up with the adder output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_valid_reg <= '0;
         tag_id_reg    <= '0;
      end else begin
         tag_valid_reg <= {tag_valid_reg[LATENCY-1:0], grant_any};
         tag_id_reg    <= {tag_id_reg[LATENCY-1:0], IDW'(grant_sel)};
      end
   end

   assign rsp_fire = tag_valid_reg[LATENCY];
   assign rsp_id   = rsp_fire ? tag_id_reg[LATENCY] : '0;
   assign rsp_sum  = add_sum;
   assign rsp_cout = add_cout;
   assign add_a    = add_a_reg;
   assign add_b    = add_b_reg;
   assign add_cin  = add_cin_reg;
   assign idle     = ~(|tag_valid_reg) & ~(|busy_reg);

endmodule

// File: tb/tb_rca_share_arbiter.sv
// tb_rca_share_arbiter
// Directed bench for rca_share_arbiter. A golden adder with the same edge latency
// closes the loop on add_*. Cycle k of each scenario is the cycle before edge Ek.
// Inputs are driven just after a rising edge; outputs are checked mid-cycle.
`timescale 1ns/1ps
module tb_rca_share_arbiter;
   localparam int NREQ    = 4;
   localparam int WIDTH   = 4;
   localparam int LATENCY = 3;
   localparam int IDW     = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   hold;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ*WIDTH-1:0]  req_a;
   logic [NREQ*WIDTH-1:0]  req_b;
   logic [NREQ-1:0]        req_cin;
   logic [NREQ-1:0]        req_ready;
   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic                   add_cin;
   logic [WIDTH-1:0]       add_sum;
   logic                   add_cout;
   logic [NREQ-1:0]        rsp_valid;
   logic [IDW-1:0]         rsp_id;
   logic [WIDTH-1:0]       rsp_sum;
   logic                   rsp_cout;
   logic                   idle;

   int total = 0;
   int bad   = 0;

   logic [WIDTH:0] adder_pipe [LATENCY];

   rca_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
      .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
      .idle(idle)
   );

   always #5 clk = ~clk;

   // Golden adder: sum of the registered operands, delayed by LATENCY edges, never reset.
   always @(posedge clk) begin
      adder_pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
      for (int i = 1; i < LATENCY; i++) adder_pipe[i] <= adder_pipe[i-1];
   end
   assign add_sum  = adder_pipe[LATENCY-1][WIDTH-1:0];
   assign add_cout = adder_pipe[LATENCY-1][WIDTH];

   // One line per transaction: issues and responses.
   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i])
            $display("%0t issue req=%0d a=%h b=%h cin=%b", $time, i,
                     req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH], req_cin[i]);
         if (rsp_valid[i])
            $display("%0t resp req=%0d id=%0d sum=%h cout=%b", $time, i, rsp_id, rsp_sum, rsp_cout);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      rst_n = 1'b0; hold = 1'b0; req_valid = '0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   // Global operand set: r0 1+2+0=3, r1 5+6+1=C, r2 A+7+1=12, r3 F+1+1=11.
   task automatic set_ops;
      req_a = 16'hFA51; req_b = 16'h1762; req_cin = 4'b1110;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; hold = 1'b0; req_valid = 4'hF; set_ops();
      tick(); #3;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset ready got=%b exp=0000", req_ready); end
      total++; if (rsp_valid !== 4'h0) begin bad++; $display("FAIL reset rsp_valid got=%b exp=0000", rsp_valid); end
      total++; if (rsp_id !== 3'd0) begin bad++; $display("FAIL reset rsp_id got=%0d exp=0", rsp_id); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset idle got=%b exp=1", idle); end
      total++; if ({add_a, add_b, add_cin} !== 9'd0) begin bad++; $display("FAIL reset add_regs got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin); end
      req_valid = '0;
      tick();
      rst_n = 1'b1; #3;
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset release idle got=%b exp=1", idle); end
   endtask

   task automatic test_single;
      logic [NREQ-1:0] er, ev;
      logic            ei;
      apply_reset();
      req_a = 16'hFA59; req_b = 16'h1768; req_cin = 4'b1111;
      req_valid = 4'b0001;
      for (int k = 0; k < 6; k++) begin
         #3;
         er = (k == 0) ? 4'b0001 : 4'b0000;
         ev = (k == 4) ? 4'b0001 : 4'b0000;
         ei = (k == 0 || k == 5);
         total++; if (req_ready !== er) begin bad++; $display("FAIL single ready k=%0d got=%b exp=%b", k, req_ready, er); end
         total++; if (rsp_valid !== ev) begin bad++; $display("FAIL single rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, ev); end
         total++; if (idle !== ei) begin bad++; $display("FAIL single idle k=%0d got=%b exp=%b", k, idle, ei); end
         if (k == 1) begin
            total++; if ({add_a, add_b, add_cin} !== {4'h9, 4'h8, 1'b1}) begin bad++; $display("FAIL single add_regs got=%h/%h/%b exp=9/8/1", add_a, add_b, add_cin); end
         end
         if (k == 4) begin
            total++; if ({rsp_cout, rsp_sum} !== 5'h12) begin bad++; $display("FAIL single result got=%b/%h exp=1/2", rsp_cout, rsp_sum); end
            total++; if (rsp_id !== 3'd0) begin bad++; $display("FAIL single rsp_id got=%0d exp=0", rsp_id); end
         end
         tick();
         req_valid = '0;
      end
   endtask

   task automatic test_all_requesters;
      logic [3:0] rdy_t [10];
      logic [3:0] rsp_t [10];
      logic [4:0] res_t [10];
      logic [2:0] id_t  [10];
      rdy_t = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
      rsp_t = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h1};
      res_t = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h03, 5'h0C, 5'h12, 5'h11, 5'h00, 5'h03};
      id_t  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
      apply_reset();
      set_ops();
      req_valid = 4'hF;
      for (int k = 0; k < 10; k++) begin
         #3;
         total++; if (req_ready !== rdy_t[k]) begin bad++; $display("FAIL all ready k=%0d got=%b exp=%b", k, req_ready, rdy_t[k]); end
         total++; if (rsp_valid !== rsp_t[k]) begin bad++; $display("FAIL all rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, rsp_t[k]); end
         if (rsp_t[k] != 4'h0) begin
            total++; if ({rsp_cout, rsp_sum} !== res_t[k]) begin bad++; $display("FAIL all result k=%0d got=%b/%h exp=%h", k, rsp_cout, rsp_sum, res_t[k]); end
            total++; if (rsp_id !== id_t[k]) begin bad++; $display("FAIL all rsp_id k=%0d got=%0d exp=%0d", k, rsp_id, id_t[k]); end
         end
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) tick();
      #3;
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL all drain idle got=%b exp=1", idle); end
   endtask

   task automatic test_busy_blocking;
      logic [NREQ-1:0] er, ev;
      apply_reset();
      set_ops();
      req_valid = 4'b0100;
      for (int k = 0; k < 11; k++) begin
         #3;
         er = (k % 5 == 0) ? 4'b0100 : 4'b0000;
         ev = (k % 5 == 4) ? 4'b0100 : 4'b0000;
         total++; if (req_ready !== er) begin bad++; $display("FAIL busy ready k=%0d got=%b exp=%b", k, req_ready, er); end
         total++; if (rsp_valid !== ev) begin bad++; $display("FAIL busy rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, ev); end
         if (ev != 4'b0000) begin
            total++; if ({rsp_cout, rsp_sum, rsp_id} !== {5'h12, 3'd2}) begin bad++; $display("FAIL busy result k=%0d got=%b/%h/%0d exp=1/2/2", k, rsp_cout, rsp_sum, rsp_id); end
         end
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) tick();
   endtask

   task automatic test_pointer_resume;
      logic [3:0] rdy_t [11];
      logic [3:0] rsp_t [11];
      logic [4:0] res_t [11];
      rdy_t = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2, 4'h0, 4'h0, 4'h0, 4'h8};
      rsp_t = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h2};
      res_t = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h0C, 5'h00, 5'h00, 5'h00, 5'h00, 5'h11, 5'h0C};
      apply_reset();
      set_ops();
      for (int k = 0; k < 11; k++) begin
         req_valid = (k == 0) ? 4'b0010 : ((k >= 5) ? 4'b1010 : 4'b0000);
         #3;
         total++; if (req_ready !== rdy_t[k]) begin bad++; $display("FAIL ptr ready k=%0d got=%b exp=%b", k, req_ready, rdy_t[k]); end
         total++; if (rsp_valid !== rsp_t[k]) begin bad++; $display("FAIL ptr rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, rsp_t[k]); end
         if (rsp_t[k] != 4'h0) begin
            total++; if ({rsp_cout, rsp_sum} !== res_t[k]) begin bad++; $display("FAIL ptr result k=%0d got=%b/%h exp=%h", k, rsp_cout, rsp_sum, res_t[k]); end
         end
         tick();
      end
      req_valid = '0;
      for (int k = 0; k < 6; k++) tick();
   endtask

   task automatic test_hold;
      logic [3:0] rdy_t [9];
      logic [3:0] rsp_t [9];
      logic [4:0] res_t [9];
      rdy_t = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8};
      rsp_t = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0};
      res_t = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h03, 5'h0C, 5'h12, 5'h00, 5'h00};
      apply_reset();
      set_ops();
      for (int k = 0; k < 9; k++) begin
         req_valid = (k < 3) ? 4'b0111 : 4'b1111;
         hold      = (k >= 3 && k <= 7);
         #3;
         total++; if (req_ready !== rdy_t[k]) begin bad++; $display("FAIL hold ready k=%0d got=%b exp=%b", k, req_ready, rdy_t[k]); end
         total++; if (rsp_valid !== rsp_t[k]) begin bad++; $display("FAIL hold rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, rsp_t[k]); end
         if (rsp_t[k] != 4'h0) begin
            total++; if ({rsp_cout, rsp_sum} !== res_t[k]) begin bad++; $display("FAIL hold result k=%0d got=%b/%h exp=%h", k, rsp_cout, rsp_sum, res_t[k]); end
         end
         tick();
      end
      hold = 1'b0; req_valid = '0;
      for (int k = 0; k < 6; k++) tick();
      #3;
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL hold drain idle got=%b exp=1", idle); end
   endtask

   task automatic test_reset_mid;
      logic [NREQ-1:0] er, ev;
      logic            ei;
      apply_reset();
      set_ops();
      req_valid = 4'b0011;
      #3;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL midrst ready k=0 got=%b exp=0001", req_ready); end
      tick(); #3;
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL midrst ready k=1 got=%b exp=0010", req_ready); end
      tick();
      rst_n = 1'b0; req_valid = 4'hF;
      #3;
      total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL midrst ready in reset got=%b exp=0000", req_ready); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL midrst idle in reset got=%b exp=1", idle); end
      total++; if ({add_a, add_b, add_cin} !== 9'd0) begin bad++; $display("FAIL midrst add_regs got=%h/%h/%b exp=0/0/0", add_a, add_b, add_cin); end
      total++; if ({rsp_valid, rsp_id} !== 7'd0) begin bad++; $display("FAIL midrst rsp got=%b/%0d exp=0000/0", rsp_valid, rsp_id); end
      tick();
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      for (int k = 4; k < 15; k++) begin
         req_valid = (k == 9) ? 4'b1010 : 4'b0000;
         #3;
         er = (k == 9) ? 4'b0010 : 4'b0000;
         ev = (k == 13) ? 4'b0010 : 4'b0000;
         ei = (k <= 9 || k == 14);
         total++; if (req_ready !== er) begin bad++; $display("FAIL midrst ready k=%0d got=%b exp=%b", k, req_ready, er); end
         total++; if (rsp_valid !== ev) begin bad++; $display("FAIL midrst rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, ev); end
         total++; if (idle !== ei) begin bad++; $display("FAIL midrst idle k=%0d got=%b exp=%b", k, idle, ei); end
         if (k == 13) begin
            total++; if ({rsp_cout, rsp_sum, rsp_id} !== {5'h0C, 3'd1}) begin bad++; $display("FAIL midrst result got=%b/%h/%0d exp=0/C/1", rsp_cout, rsp_sum, rsp_id); end
         end
         tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; req_valid = '0;
      req_a = '0; req_b = '0; req_cin = '0;
      test_reset();
      test_single();
      test_all_requesters();
      test_busy_blocking();
      test_pointer_resume();
      test_hold();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
